// File: rtl/uart_rx_frame_if.sv
// Handshake/bus bundle between the UART start detector, the frame receiver and the byte consumer.
// master drives line/tick/ready; slave (the receiver) returns the byte and status.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 sample_tick;
  logic                 start_det;
  logic                 rx;
  logic                 data_ready;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output sample_tick, start_det, rx, data_ready,
    input  data, data_valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    input  sample_tick, start_det, rx, data_ready,
    output data, data_valid, frame_err, parity_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: samples data/stop bits at bit centres after start_det and presents the byte via valid/ready.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int SAMPLE_RATE = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_ODD  = 0
) (
  input logic            i_clk,
  input logic            i_rst_n,
  uart_rx_frame_if.slave bus
);
  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (SAMPLE_RATE < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
    $error("uart_rx_frame: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_STOP   = 2'd3
  } state_t;

  state_t               r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_pend;
  logic                 r_parity_err;
`endif

  logic w_sample;
  logic w_accept;
  logic w_load;

  assign w_sample = bus.sample_tick && (r_tick_cnt == TICK_LAST);
  assign w_accept = r_data_valid && bus.data_ready;
  // A finished frame may replace the held byte only if it is gone or leaving this very edge.
  assign w_load   = !r_data_valid || bus.data_ready;

  // Frame sequencing, bit sampling and output holding registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_pend   <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_data_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
      if (bus.sample_tick && (r_state != S_IDLE)) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start_det) begin
            r_state    <= S_DATA;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_pend <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift <= {bus.rx, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_sample) begin
            r_par_pend <= bus.rx != ((^r_shift) ^ (PARITY_ODD != 0));
            r_state    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_sample) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_load) begin
              r_data       <= r_shift;
              r_frame_err  <= ~bus.rx;
              r_data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_pend;
`endif
            end else begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised-timing bench for uart_rx_frame with a behavioural model of the held byte and its status flags.
module tb_uart_rx_frame;
  localparam int SR   = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic          exp_valid = 1'b0;
  logic          exp_ferr  = 1'b0;
  logic          exp_perr  = 1'b0;
  logic          exp_ovr   = 1'b0;
  logic [DB-1:0] exp_data  = '0;

  uart_rx_frame_if #(.DATA_BITS(DB)) bus ();

  uart_rx_frame #(
    .SAMPLE_RATE(SR),
    .DATA_BITS  (DB),
    .PARITY_ODD (PODD)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return (^d) ^ (PODD != 0);
  endfunction

  // Model of a completed frame arriving at the held-byte register.
  task automatic model_complete(input logic [DB-1:0] d, input logic stop_bit, input logic par_bit);
    if (!exp_valid || bus.data_ready) begin
      if (exp_valid) exp_ovr = 1'b0;
      exp_valid = 1'b1;
      exp_data  = d;
      exp_ferr  = !stop_bit;
      exp_perr  = (PB != 0) ? (par_bit != good_par(d)) : 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic model_accept();
    if (exp_valid && bus.data_ready) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_ovr = 1'b0; exp_data = '0;
  endtask

  // Drives one frame with random tick spacing; optional stray start_det in bit noise_bit, async reset in bit rst_bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic par_bit, input logic stop_bit,
                            input int noise_bit, input int rst_bit,
                            output logic pre_valid, output logic mid_busy, output logic aborted);
    logic bits[$];
    bits = {};
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PB != 0) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    aborted   = 1'b0;
    pre_valid = 1'b0;
    bus.rx          = 1'b0;
    bus.start_det   = 1'b1;
    bus.sample_tick = 1'($urandom_range(0, 1));
    step();
    bus.start_det   = 1'b0;
    bus.sample_tick = 1'b0;
    mid_busy = bus.busy;
    for (int b = 0; b < bits.size(); b++) begin
      bus.rx = bits[b];
      for (int t = 0; t < SR; t++) begin
        repeat ($urandom_range(0, 2)) step();
        if (b == rst_bit && t == SR / 2) begin
          #2 rst_n = 1'b0;
          aborted = 1'b1;
          return;
        end
        if (b == noise_bit && t == SR / 2) begin
          bus.start_det = 1'b1;
          step();
          bus.start_det = 1'b0;
        end
        if (b == bits.size() - 1 && t == SR - 1) pre_valid = bus.data_valid;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
      end
    end
    bus.rx = 1'b1;
  endtask

  task automatic test_reset();
    bus.sample_tick = 1'b0; bus.start_det = 1'b0; bus.rx = 1'b1; bus.data_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (bus.data !== '0)        begin errors++; $display("FAIL reset_data[%0d]: got %h expected 00", k, bus.data); end
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, bus.data_valid); end
      checks++; if (bus.frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr[%0d]: got %b expected 0", k, bus.frame_err); end
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr[%0d]: got %b expected 0", k, bus.parity_err); end
      checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL reset_ovr[%0d]: got %b expected 0", k, bus.overrun); end
      checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, bus.busy); end
      rst_n = 1'b1;
      step();
    end
  endtask

  task automatic test_basic();
    logic pv, mb, ab;
    bus.data_ready = 1'b1;
    send_frame(8'hA5, good_par(8'hA5), 1'b1, -1, -1, pv, mb, ab);
    model_complete(8'hA5, 1'b1, good_par(8'hA5));
    checks++; if (mb !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", mb); end
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", pv); end
    checks++; if (bus.data_valid !== exp_valid) begin errors++; $display("FAIL basic_valid: got %b expected %b", bus.data_valid, exp_valid); end
    checks++; if (bus.data !== exp_data) begin errors++; $display("FAIL basic_data: got %h expected %h", bus.data, exp_data); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", bus.busy); end
    step(); model_accept();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", bus.data_valid); end
  endtask

  task automatic test_frame_err();
    logic pv, mb, ab;
    bus.data_ready = 1'b1;
    send_frame(8'h3C, good_par(8'h3C), 1'b0, -1, -1, pv, mb, ab);
    model_complete(8'h3C, 1'b0, good_par(8'h3C));
    checks++; if (bus.data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", bus.data); end
    checks++; if (bus.frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_flag: got %b expected %b", bus.frame_err, exp_ferr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", bus.busy); end
    step(); model_accept();
  endtask

  task automatic test_overrun();
    logic pv, mb, ab;
    bus.data_ready = 1'b0;
    send_frame(8'h11, good_par(8'h11), 1'b1, -1, -1, pv, mb, ab);
    model_complete(8'h11, 1'b1, good_par(8'h11));
    repeat (3) step();
    send_frame(8'h22, good_par(8'h22), 1'b1, -1, -1, pv, mb, ab);
    model_complete(8'h22, 1'b1, good_par(8'h22));
    checks++; if (bus.data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h expected 11", bus.data); end
    checks++; if (bus.overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b expected %b", bus.overrun, exp_ovr); end
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.data_valid); end
    bus.data_ready = 1'b1;
    step(); model_accept();
    checks++; if (bus.data_valid !== exp_valid) begin errors++; $display("FAIL ovr_accept_valid: got %b expected %b", bus.data_valid, exp_valid); end
    checks++; if (bus.overrun !== exp_ovr) begin errors++; $display("FAIL ovr_accept_clear: got %b expected %b", bus.overrun, exp_ovr); end
  endtask

  task automatic test_reset_mid_frame();
    logic pv, mb, ab;
    bus.data_ready = 1'b0;
    send_frame(8'h5A, good_par(8'h5A), 1'b1, -1, -1, pv, mb, ab);
    model_complete(8'h5A, 1'b1, good_par(8'h5A));
    send_frame(8'hFF, good_par(8'hFF), 1'b1, -1, 4, pv, mb, ab);
    #1;
    model_reset();
    checks++; if (ab !== 1'b1) begin errors++; $display("FAIL rst_mid_reached: got %b expected 1", ab); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.data_valid); end
    checks++; if (bus.data !== '0) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", bus.data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr: got %b expected 0", bus.overrun); end
    bus.sample_tick = 1'b0; bus.start_det = 1'b0; bus.rx = 1'b1;
    step();
    rst_n = 1'b1;
    bus.data_ready = 1'b1;
    step();
    send_frame(8'h81, good_par(8'h81), 1'b1, -1, -1, pv, mb, ab);
    model_complete(8'h81, 1'b1, good_par(8'h81));
    checks++; if (bus.data !== exp_data) begin errors++; $display("FAIL rst_next_data: got %h expected %h", bus.data, exp_data); end
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL rst_next_valid: got %b expected 1", bus.data_valid); end
    step(); model_accept();
  endtask

  task automatic test_start_ignored();
    logic pv, mb, ab;
    bus.data_ready = 1'b1;
    send_frame(8'h55, good_par(8'h55), 1'b1, 3, -1, pv, mb, ab);
    model_complete(8'h55, 1'b1, good_par(8'h55));
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL noise_early_valid: got %b expected 0", pv); end
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL noise_valid: got %b expected 1", bus.data_valid); end
    checks++; if (bus.data !== exp_data) begin errors++; $display("FAIL noise_data: got %h expected %h", bus.data, exp_data); end
    step(); model_accept();
  endtask

  task automatic test_random();
    logic pv, mb, ab;
    logic [DB-1:0] d;
    logic st, pa;
    for (int n = 0; n < 16; n++) begin
      bus.data_ready = 1'($urandom_range(0, 1));
      step(); model_accept();
      d  = DB'($urandom());
      st = ($urandom_range(0, 5) != 0);
      pa = good_par(d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, pa, st, -1, -1, pv, mb, ab);
      model_complete(d, st, pa);
      checks++; if (bus.data_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, bus.data_valid, exp_valid); end
      checks++; if (bus.data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, bus.data, exp_data); end
      checks++; if (bus.frame_err !== exp_ferr) begin errors++; $display("FAIL rand_ferr[%0d]: got %b expected %b", n, bus.frame_err, exp_ferr); end
      checks++; if (bus.parity_err !== exp_perr) begin errors++; $display("FAIL rand_perr[%0d]: got %b expected %b", n, bus.parity_err, exp_perr); end
      checks++; if (bus.overrun !== exp_ovr) begin errors++; $display("FAIL rand_ovr[%0d]: got %b expected %b", n, bus.overrun, exp_ovr); end
    end
    bus.data_ready = 1'b1;
    step(); model_accept();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rand_drain: got %b expected 0", bus.data_valid); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic pv, mb, ab;
    bus.data_ready = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1, -1, -1, pv, mb, ab);
    checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", bus.parity_err); end
    step();
    send_frame(8'h07, 1'b1, 1'b1, -1, -1, pv, mb, ab);
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", bus.parity_err); end
    checks++; if (bus.data !== 8'h07) begin errors++; $display("FAIL parity_data: got %h expected 07", bus.data); end
    step();
    model_reset();
    exp_data = 8'h07;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_start_ignored();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Downstream stage of the UART receive start-bit detector. It accepts the one-cycle start-detected pulse, which arrives at the middle of the start bit, together with the oversampling tick stream. It then samples the data bits at their centres, checks the stop bit and hands the received byte to the consumer over a valid/ready handshake, flagging framing and overrun errors.

## Interface
- SAMPLE_RATE, 16, oversampling ticks per bit period (≥ 4)
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only with UART_RX_PARITY_EN

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-clk enable pulse, SAMPLE_RATE per bit period
- start_det  input  1  one-clk pulse; start bit confirmed at its centre
- rx  input  1  serial line, already synchronised upstream
- data  output  DATA_BITS  received byte, LSB = first bit on the line
- data_valid  output  1  data/frame_err/parity_err hold a byte
- data_ready  input  1  consumer accepts when high with data_valid
- frame_err  output  1  stop bit of the held byte sampled 0
- parity_err  output  1  parity mismatch on the held byte (tied 0 without macro)
- overrun  output  1  sticky: a frame completed while the previous byte was unaccepted
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, DATA, PARITY (macro only), STOP.
- IDLE: start_det=1 → DATA; tick_cnt=0, bit_cnt=0. start_det is ignored in every other state.
- The tick counter ($clog2(SAMPLE_RATE) bits) increments only on sample_tick. On the tick where tick_cnt == SAMPLE_RATE-1, rx is sampled and tick_cnt wraps to 0. Each sample therefore lands one full bit period after the previous centre.
- DATA: each sample shifts rx into the shift register MSB and shifts right. After DATA_BITS samples → PARITY if the macro is defined, else → STOP.
- PARITY: one sample, compared against XOR of the data bits XOR PARITY_ODD; a mismatch latches a pending parity error → STOP.
- STOP: one sample; rx=0 means framing error. The frame then completes → IDLE.
- Completion with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle:
  - load data, frame_err and parity_err
  - data_valid=1
- Completion with data_valid=1 and data_ready=0:
  - the new frame is discarded
  - the held byte is unchanged
  - overrun=1
- Accept is data_valid && data_ready at a clk edge. On accept, data_valid=0 next cycle unless the simultaneous-completion case above applies. overrun clears on accept.
- frame_err and parity_err qualify the held byte only; they are valid while data_valid=1.
- Framing error: the block does not wait for line idle. It returns to IDLE, and the start detector governs re-arming.

## Timing
- Reset values: data=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE, counters=0.
- Reset is asynchronous: asserting rst_n mid-frame aborts the frame with no output. After release the block sits in IDLE.
- busy rises the cycle after start_det.
- data_valid rises the clk cycle after the stop-bit sampling tick.
- Frame duration from start_det to the stop sample is (DATA_BITS+1[+1 parity])·SAMPLE_RATE sample_ticks.
- sample_tick and start_det in the same cycle: the tick is not counted.
- data_ready may be held high permanently; data_valid is then a 1-cycle pulse per byte.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists, one parity bit is expected between data and stop, and parity_err is driven.
- Not defined: there is no PARITY state, the frame is start+data+stop, and parity_err is constant 0.

## Test plan
- 0xA5, 8N1, SAMPLE_RATE=16, ready=1 → data=0xA5, data_valid 1-cycle pulse 144 ticks after start_det, frame_err=0.
- 0x3C with stop bit driven 0 → data=0x3C, frame_err=1, busy=0 after completion.
- Two frames 0x11 then 0x22, ready=0 throughout → data stays 0x11, overrun=1. Raise ready → accept; overrun=0, data_valid=0.
- Reset pulse at data bit 4 of 0xFF → all outputs 0 immediately. The next frame 0x81 is received correctly.
- start_det pulses during DATA of 0x55 → ignored, data=0x55 with correct timing.
- Macro on, even parity, 0x07 with parity bit 0 → parity_err=1. With parity bit 1 → parity_err=0.
